// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART framing constants and transmit state encoding
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS     = 8;
    localparam int UART_FRAME_BITS    = 10;
    localparam int CHACHA_BLOCK_BYTES = 64;

endpackage

// File: rtl/uart_block_tx_baud_tick.sv
// rtl/uart_block_tx_baud_tick.sv - system-clock divider producing one-clock oversample ticks
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   clr  - holds the divider at 0 (no ticks while asserted)
//   tick - one-clock pulse each time the divider wraps at CLK_DIV-1
module baud_tick #(
    parameter int CLK_DIV = 11
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(CLK_DIV - 1));
    assign tick = wrap && !clr;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_block_tx.sv
// rtl/uart_block_tx.sv - sends one NBYTES block as back-to-back 8N1 frames, byte 0 first
// Ports:
//   clk, rst             - system clock, synchronous active-high reset
//   blk_valid/blk_ready  - block handshake; accepted when both are high (ready only in IDLE)
//   blk_data             - block to send, byte 0 in blk_data[7:0]
//   busy                 - high while a block is on the line
//   done                 - one-clock pulse when the last stop bit has completed
//   txd                  - serial line, idle high
module uart_block_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 11,
    parameter int OVERSAMPLE = 16,
    parameter int NBYTES     = CHACHA_BLOCK_BYTES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                blk_valid,
    output logic                blk_ready,
    input  logic [8*NBYTES-1:0] blk_data,
    output logic                busy,
    output logic                done,
    output logic                txd
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_START = START;
    localparam logic [1:0] S_DATA  = DATA;
    localparam logic [1:0] S_STOP  = STOP;

    localparam int OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [1:0]          state_q, state_d;
    logic [OS_W-1:0]     ovs_q, ovs_d;
    logic [2:0]          bit_q, bit_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [8*NBYTES-1:0] shreg_q, shreg_d;
    logic                txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                blk_ready_q, blk_ready_d;
    logic                done_q, done_d;

    logic       tick;
    logic       ovs_wrap;
    logic       bit_end;
    logic       accept;
    logic [7:0] cur_byte_d;

    // Divider runs only while a frame is on the line, so the first bit after
    // acceptance starts from a fresh count and is full length.
    baud_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (state_q == S_IDLE),
        .tick(tick)
    );

    assign ovs_wrap = (ovs_q == OS_W'(OVERSAMPLE - 1));
    assign bit_end  = tick && ovs_wrap;
    assign accept   = blk_valid && blk_ready_q;

    always_comb begin
        state_d    = state_q;
        ovs_d      = ovs_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        shreg_d    = shreg_q;
        done_d     = 1'b0;
        cur_byte_d = '0;
        txd_d      = 1'b1;

        if (state_q != S_IDLE && tick) begin
            ovs_d = ovs_wrap ? '0 : ovs_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                ovs_d = '0;
                bit_d = '0;
                idx_d = '0;
                if (accept) begin
                    shreg_d = blk_data;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                if (bit_end) begin
                    if (idx_q == IDX_W'(NBYTES - 1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shreg_d = shreg_q >> 8;
                        state_d = S_START;
                    end
                end
            end
        endcase

        // Outputs are registered from next-state values so they change on the
        // same edge as the state itself, with no input-to-output comb path.
        cur_byte_d = shreg_d[7:0];
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = cur_byte_d[bit_d];
            default: txd_d = 1'b1;
        endcase
        busy_d      = (state_d != S_IDLE);
        blk_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ovs_q       <= '0;
            bit_q       <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            blk_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ovs_q       <= ovs_d;
            bit_q       <= bit_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            blk_ready_q <= blk_ready_d;
            done_q      <= done_d;
        end
    end

    assign txd       = txd_q;
    assign busy      = busy_q;
    assign blk_ready = blk_ready_q;
    assign done      = done_q;

endmodule
